// File: rtl/controller_multicycle.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute,
// memory, branch, jump and halt over a shared datapath and memory.
module controller_multicycle #(
  parameter bit         MEM_WAIT_EN  = 1'b1,
  parameter bit         ILLEGAL_TRAP = 1'b1,
  parameter logic [6:0] HALT_OPCODE  = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero_flag,
  input  logic       lt_flag,
  input  logic       ltu_flag,
  input  logic       mem_ready,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [2:0] mem_size,
  output logic       reg_write,
  output logic [1:0] out_mux_sel,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a_sel,
  output logic [1:0] alu_src_b_sel,
  output logic [3:0] alu_ctrl,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    RESET, FETCH, DECODE, EXECUTE, MEM_ADR, MEM_READ, MEM_WRITE,
    WRITE_BACK, BRANCH, JUMP, HALT, MEM_WB, JUMP_PC
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] A_ADD  = 4'h1;
  localparam logic [3:0] A_SUB  = 4'h2;
  localparam logic [3:0] A_XOR  = 4'h3;
  localparam logic [3:0] A_OR   = 4'h4;
  localparam logic [3:0] A_AND  = 4'h5;
  localparam logic [3:0] A_SLL  = 4'h6;
  localparam logic [3:0] A_SRL  = 4'h7;
  localparam logic [3:0] A_SRA  = 4'h8;
  localparam logic [3:0] A_SLT  = 4'h9;
  localparam logic [3:0] A_SLTU = 4'hA;

  state_e state_q, state_d;
  logic   ready;
  logic   taken;
  logic   f7_alt;
  logic   f7_zero;
  logic [3:0] r_alu, i_alu;

  assign ready   = mem_ready | ~MEM_WAIT_EN;
  assign f7_alt  = (funct7 == 7'h20);
  assign f7_zero = (funct7 == 7'h00);
  assign state   = state_q;
  assign halted  = (state_q == HALT);

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = zero_flag;
      3'b001:  taken = ~zero_flag;
      3'b100:  taken = lt_flag;
      3'b101:  taken = ~lt_flag;
      3'b110:  taken = ltu_flag;
      3'b111:  taken = ~ltu_flag;
      default: taken = 1'b0;
    endcase
  end

  // R-type: only funct7 0x00, or 0x20 on ADD/SRL slots, is meaningful
  always_comb begin
    r_alu = A_ADD;
    unique case (funct3)
      3'b000: r_alu = f7_alt ? A_SUB : A_ADD;
      3'b001: r_alu = A_SLL;
      3'b010: r_alu = A_SLT;
      3'b011: r_alu = A_SLTU;
      3'b100: r_alu = A_XOR;
      3'b101: r_alu = f7_alt ? A_SRA : A_SRL;
      3'b110: r_alu = A_OR;
      3'b111: r_alu = A_AND;
    endcase
    if (!(f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101))))
      r_alu = A_ADD;
  end

  always_comb begin
    i_alu = A_ADD;
    unique case (funct3)
      3'b000: i_alu = A_ADD;
      3'b001: i_alu = f7_zero ? A_SLL : A_ADD;
      3'b010: i_alu = A_SLT;
      3'b011: i_alu = A_SLTU;
      3'b100: i_alu = A_XOR;
      3'b101: i_alu = f7_alt ? A_SRA : (f7_zero ? A_SRL : A_ADD);
      3'b110: i_alu = A_OR;
      3'b111: i_alu = A_AND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET:  state_d = FETCH;
      FETCH:  if (ready) state_d = DECODE;
      DECODE: begin
        if (opcode == HALT_OPCODE) state_d = HALT;
        else begin
          unique case (opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: state_d = EXECUTE;
            OP_LOAD, OP_STORE:            state_d = MEM_ADR;
            OP_BR:                        state_d = BRANCH;
            OP_JAL, OP_JALR:              state_d = JUMP;
            default: state_d = ILLEGAL_TRAP ? HALT : FETCH;
          endcase
        end
      end
      EXECUTE:    state_d = WRITE_BACK;
      WRITE_BACK: state_d = FETCH;
      MEM_ADR:    state_d = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
      MEM_READ:   if (ready) state_d = MEM_WB;
      MEM_WB:     state_d = FETCH;
      MEM_WRITE:  if (ready) state_d = FETCH;
      BRANCH:     state_d = FETCH;
      JUMP:       state_d = JUMP_PC;
      JUMP_PC:    state_d = FETCH;
      HALT:       state_d = HALT;
      default:    state_d = RESET;
    endcase
  end

  always_comb begin
    adr_src       = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_size      = 3'b010;
    reg_write     = 1'b0;
    out_mux_sel   = 2'b01;
    imm_sel       = 3'b000;
    alu_src_a_sel = 2'b01;
    alu_src_b_sel = 2'b10;
    alu_ctrl      = A_ADD;
    unique case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        if (ready) begin
          ir_write    = 1'b1;
          pc_write    = 1'b1;
          out_mux_sel = 2'b00;
        end
      end
      DECODE: begin
        alu_src_a_sel = 2'b11;
        alu_src_b_sel = 2'b01;
        imm_sel       = 3'b010;
      end
      EXECUTE: begin
        alu_src_a_sel = 2'b10;
        alu_src_b_sel = 2'b01;
        if (opcode == OP_R) begin
          alu_src_b_sel = 2'b00;
          alu_ctrl      = r_alu;
        end else if (opcode == OP_I) begin
          imm_sel  = 3'b001;
          alu_ctrl = i_alu;
        end else begin
          imm_sel       = 3'b100;
          alu_src_a_sel = (opcode == OP_LUI) ? 2'b00 : 2'b11;
        end
      end
      WRITE_BACK: reg_write = 1'b1;
      MEM_ADR: begin
        alu_src_a_sel = 2'b10;
        alu_src_b_sel = 2'b01;
        imm_sel = (opcode == OP_STORE) ? 3'b011 : 3'b001;
      end
      MEM_READ: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        mem_size = funct3;
      end
      MEM_WB: begin
        reg_write   = 1'b1;
        out_mux_sel = 2'b10;
      end
      MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        mem_size  = funct3;
      end
      BRANCH: begin
        alu_src_a_sel = 2'b10;
        alu_src_b_sel = 2'b00;
        alu_ctrl      = A_SUB;
        pc_write      = taken;
      end
      JUMP: begin
        reg_write     = 1'b1;
        out_mux_sel   = 2'b11;
        alu_src_b_sel = 2'b01;
        if (opcode == OP_JALR) begin
          alu_src_a_sel = 2'b10;
          imm_sel       = 3'b001;
        end else begin
          alu_src_a_sel = 2'b11;
          imm_sel       = 3'b101;
        end
      end
      JUMP_PC: pc_write = 1'b1;
      default: ;
    endcase
    if (!rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_controller_multicycle.sv
// Directed bench for controller_multicycle: one waiting/no-trap
// instance and one single-cycle-memory/trapping instance.
module tb_controller_multicycle;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero_flag, lt_flag, ltu_flag, mem_ready;

  logic       a_adr, a_pcw, a_irw, a_mrd, a_mwr, a_rw, a_halt;
  logic [2:0] a_msz, a_imm;
  logic [1:0] a_om, a_sa, a_sb;
  logic [3:0] a_alu, a_st;

  logic       b_adr, b_pcw, b_irw, b_mrd, b_mwr, b_rw, b_halt;
  logic [2:0] b_msz, b_imm;
  logic [1:0] b_om, b_sa, b_sb;
  logic [3:0] b_alu, b_st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controller_multicycle #(
    .MEM_WAIT_EN(1'b1), .ILLEGAL_TRAP(1'b0), .HALT_OPCODE(7'h7F)
  ) u_a (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .zero_flag(zero_flag), .lt_flag(lt_flag),
    .ltu_flag(ltu_flag), .mem_ready(mem_ready),
    .adr_src(a_adr), .pc_write(a_pcw), .ir_write(a_irw),
    .mem_read(a_mrd), .mem_write(a_mwr), .mem_size(a_msz),
    .reg_write(a_rw), .out_mux_sel(a_om), .imm_sel(a_imm),
    .alu_src_a_sel(a_sa), .alu_src_b_sel(a_sb), .alu_ctrl(a_alu),
    .halted(a_halt), .state(a_st)
  );

  controller_multicycle #(
    .MEM_WAIT_EN(1'b0), .ILLEGAL_TRAP(1'b1), .HALT_OPCODE(7'h7F)
  ) u_b (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .zero_flag(zero_flag), .lt_flag(lt_flag),
    .ltu_flag(ltu_flag), .mem_ready(mem_ready),
    .adr_src(b_adr), .pc_write(b_pcw), .ir_write(b_irw),
    .mem_read(b_mrd), .mem_write(b_mwr), .mem_size(b_msz),
    .reg_write(b_rw), .out_mux_sel(b_om), .imm_sel(b_imm),
    .alu_src_a_sel(b_sa), .alu_src_b_sel(b_sb), .alu_ctrl(b_alu),
    .halted(b_halt), .state(b_st)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    zero_flag = 1'b0; lt_flag = 1'b0; ltu_flag = 1'b0;
    mem_ready = 1'b0;
    tick(); tick();
    chk("rst_state", 8'(a_st), 8'd0);
    chk("rst_msize", 8'(a_msz), 8'd2);
    chk("rst_alu", 8'(a_alu), 8'd1);
    chk("rst_omux", 8'(a_om), 8'd1);
    chk("rst_srca", 8'(a_sa), 8'd1);
    chk("rst_srcb", 8'(a_sb), 8'd2);
    chk("rst_imm", 8'(a_imm), 8'd0);
    chk("rst_halt", 8'(a_halt), 8'd0);
    chk("rst_mrd", 8'(a_mrd), 8'd0);

    // store, then reset in the middle of the write wait
    rst = 1'b1; opcode = 7'b0100011; funct3 = 3'b000;
    tick();
    chk("f_state", 8'(a_st), 8'd1);
    chk("f_mrd", 8'(a_mrd), 8'd1);
    chk("f_irw_wait", 8'(a_irw), 8'd0);
    chk("f_adr", 8'(a_adr), 8'd0);
    mem_ready = 1'b1; #1;
    chk("f_irw", 8'(a_irw), 8'd1);
    chk("f_pcw", 8'(a_pcw), 8'd1);
    chk("f_omux", 8'(a_om), 8'd0);
    tick();
    chk("d_state", 8'(a_st), 8'd2);
    chk("d_imm", 8'(a_imm), 8'd2);
    chk("d_srca", 8'(a_sa), 8'd3);
    chk("d_srcb", 8'(a_sb), 8'd1);
    mem_ready = 1'b0;
    tick();
    chk("ma_state", 8'(a_st), 8'd4);
    chk("ma_imm_s", 8'(a_imm), 8'd3);
    chk("ma_srca", 8'(a_sa), 8'd2);
    tick();
    chk("mw_state", 8'(a_st), 8'd6);
    chk("mw_mwr", 8'(a_mwr), 8'd1);
    chk("mw_msize", 8'(a_msz), 8'd0);
    chk("mw_adr", 8'(a_adr), 8'd1);
    tick();
    chk("mw_hold", 8'(a_st), 8'd6);
    rst = 1'b0; #1;
    chk("mw_gate", 8'(a_mwr), 8'd0);
    chk("mw_gate_st", 8'(a_st), 8'd6);
    tick();
    chk("rst1", 8'(a_st), 8'd0);
    tick(); tick();
    chk("rst3", 8'(a_st), 8'd0);
    rst = 1'b1;
    tick();
    chk("rst_exit", 8'(a_st), 8'd1);

    // SB with write held until ready
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("sb_state", 8'(a_st), 8'd6);
    tick();
    chk("sb_hold", 8'(a_mwr), 8'd1);
    mem_ready = 1'b1; #1;
    chk("sb_ready_st", 8'(a_st), 8'd6);
    chk("sb_ready_mwr", 8'(a_mwr), 8'd1);
    tick();
    chk("sb_done", 8'(a_st), 8'd1);

    // LW with three wait cycles
    opcode = 7'b0000011; funct3 = 3'b010;
    tick(); tick();
    chk("lw_ma_imm", 8'(a_imm), 8'd1);
    mem_ready = 1'b0;
    tick();
    chk("lw_state", 8'(a_st), 8'd5);
    chk("lw_mrd", 8'(a_mrd), 8'd1);
    chk("lw_msize", 8'(a_msz), 8'd2);
    chk("lw_adr", 8'(a_adr), 8'd1);
    tick(); tick();
    chk("lw_c3", 8'(a_st), 8'd5);
    mem_ready = 1'b1; #1;
    chk("lw_c4", 8'(a_st), 8'd5);
    chk("lw_c4_mrd", 8'(a_mrd), 8'd1);
    tick();
    chk("wb_state", 8'(a_st), 8'd11);
    chk("wb_omux", 8'(a_om), 8'd2);
    chk("wb_rw", 8'(a_rw), 8'd1);
    tick();
    chk("lw_done", 8'(a_st), 8'd1);

    // BNE not taken
    opcode = 7'b1100011; funct3 = 3'b001; zero_flag = 1'b1;
    tick(); tick();
    chk("bne_state", 8'(a_st), 8'd8);
    chk("bne_pcw", 8'(a_pcw), 8'd0);
    chk("bne_alu", 8'(a_alu), 8'd2);
    tick();

    // BLTU taken, then flag drop
    funct3 = 3'b110; zero_flag = 1'b0; ltu_flag = 1'b1;
    tick(); tick();
    chk("bltu_pcw", 8'(a_pcw), 8'd1);
    chk("bltu_omux", 8'(a_om), 8'd1);
    ltu_flag = 1'b0; #1;
    chk("bltu_nt", 8'(a_pcw), 8'd0);
    tick();
    chk("br_done", 8'(a_st), 8'd1);

    // JALR
    opcode = 7'b1100111; funct3 = 3'b000;
    tick(); tick();
    chk("j_state", 8'(a_st), 8'd9);
    chk("j_rw", 8'(a_rw), 8'd1);
    chk("j_omux", 8'(a_om), 8'd3);
    chk("j_srca", 8'(a_sa), 8'd2);
    chk("j_imm", 8'(a_imm), 8'd1);
    tick();
    chk("jpc_state", 8'(a_st), 8'd12);
    chk("jpc_pcw", 8'(a_pcw), 8'd1);
    tick();
    chk("j_done", 8'(a_st), 8'd1);

    // unknown opcode treated as NOP
    opcode = 7'h00;
    tick(); tick();
    chk("nop_fetch", 8'(a_st), 8'd1);

    // halt and stay halted
    opcode = 7'h7F;
    tick(); tick();
    chk("halt_state", 8'(a_st), 8'd10);
    chk("halt_flag", 8'(a_halt), 8'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold", 8'(a_halt), 8'd1);
      chk("halt_pcw", 8'(a_pcw), 8'd0);
    end
    rst = 1'b0;
    tick();
    chk("halt_rst", 8'(a_st), 8'd0);
    chk("halt_clr", 8'(a_halt), 8'd0);

    // single-cycle memory instance: ADD then SUB
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h00;
    mem_ready = 1'b0; rst = 1'b1;
    tick();
    chk("nw_f", 8'(b_st), 8'd1);
    chk("nw_irw", 8'(b_irw), 8'd1);
    tick();
    chk("nw_d", 8'(b_st), 8'd2);
    tick();
    chk("add_state", 8'(b_st), 8'd3);
    chk("add_alu", 8'(b_alu), 8'd1);
    chk("add_rw", 8'(b_rw), 8'd0);
    chk("add_srca", 8'(b_sa), 8'd2);
    chk("add_srcb", 8'(b_sb), 8'd0);
    tick();
    chk("add_wb", 8'(b_st), 8'd7);
    chk("add_wb_rw", 8'(b_rw), 8'd1);
    funct7 = 7'h20;
    tick();
    chk("sub_f", 8'(b_st), 8'd1);
    tick(); tick();
    chk("sub_state", 8'(b_st), 8'd3);
    chk("sub_alu", 8'(b_alu), 8'd2);
    tick();
    chk("sub_wb_rw", 8'(b_rw), 8'd1);
    tick();

    // trapping instance: unknown opcode halts
    opcode = 7'h00;
    tick(); tick();
    chk("trap_state", 8'(b_st), 8'd10);
    chk("trap_halt", 8'(b_halt), 8'd1);
    chk("wait_stall", 8'(a_st), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
